// File: rtl/apb_master.sv
// APB4 requester: takes single transfers from a valid/ready command port, runs them
// through the SETUP/ACCESS phases and returns a registered one-cycle completion.
module apb_master #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 10,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                      pclk,
    input  logic                      preset,
    // command port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_write,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [BYTES_PER_WORD-1:0] req_strb,
    input  logic [2:0]                req_prot,
    // response port
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    // APB bus
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [BYTES_PER_WORD-1:0] pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam bit             TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam int             CNT_W     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int             TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [2:0]                prot;
        logic                      write;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [BYTES_PER_WORD-1:0] strb;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             load, done, abort, cnt_inc;

    // Read strobes are forced low so the completer never sees byte lanes on a read.
    always_comb begin
        cmd_d.addr  = req_addr;
        cmd_d.prot  = req_prot;
        cmd_d.write = req_write;
        cmd_d.wdata = req_wdata;
        cmd_d.strb  = req_write ? req_strb : '0;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready wins over a timeout landing on the same cycle
                if (pready) begin
                    req_ready = 1'b1;
                    done      = 1'b1;
                    if (req_valid) begin
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TO_EN && wait_cnt == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = TO_EN;
                end
            end
            default: state_d = IDLE;
        endcase
        // a request offered during reset must not see a handshake that reset then discards
        if (preset) req_ready = 1'b0;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= done | abort;
            if (load) begin
                cmd_q    <= cmd_d;
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done) begin
                rsp_rdata   <= cmd_q.write ? '0 : prdata;
                rsp_error   <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_error   <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable = (state_q == ACCESS);
    assign paddr   = cmd_q.addr;
    assign pprot   = cmd_q.prot;
    assign pwrite  = cmd_q.write;
    assign pwdata  = cmd_q.wdata;
    assign pstrb   = cmd_q.strb;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level model predicts each
// completion (cycle count, status, data) from wait-state count and timeout limit.
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_error, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [BW-1:0] pstrb;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;

    apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] strb;
        logic [DW-1:0] rdata;   // what the completer returns
        logic          err;     // pslverr at completion
        int            w;       // wait states before pready
        bit            chain;   // offer the next request on the completion cycle
    } txn_t;

    txn_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [63:0] bus_obs;
    assign bus_obs = {14'b0, paddr, pprot, pwrite, pwdata, pstrb};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] bus_exp(input txn_t t);
        return {14'b0, t.addr, t.prot, t.wr, t.wdata, t.wr ? t.strb : {BW{1'b0}}};
    endfunction

    function automatic txn_t mk(input logic [AW-1:0] a, input logic [2:0] p, input logic wr,
                                input logic [DW-1:0] wd, input logic [BW-1:0] s,
                                input logic [DW-1:0] rd, input logic e, input int w,
                                input bit ch);
        txn_t t;
        t.addr = a; t.prot = p; t.wr = wr; t.wdata = wd; t.strb = s;
        t.rdata = rd; t.err = e; t.w = w; t.chain = ch;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_prot  = t.prot;
        req_write = t.wr;
        req_wdata = t.wdata;
        req_strb  = t.strb;
    endtask

    // Runs everything queued in q; called at a negedge with the DUT idle.
    task automatic run_q();
        bit   pre = 1'b0;
        txn_t t;
        int   acc;
        bit   last, tout;
        while (q.size() > 0) begin
            t = q.pop_front();
            if (!pre) begin
                drive_req(t);
                #1 chk("idle_ready", req_ready, 1'b1);
                chk("idle_sel", {psel, penable}, 2'b00);
                @(negedge pclk);
            end
            req_valid = 1'b0;
            chk("setup_sel", {psel, penable}, 2'b10);
            chk("setup_bus", bus_obs, bus_exp(t));
            // bus inputs are don't-care outside ACCESS
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            #1 chk("setup_ready", req_ready, 1'b0);
            @(negedge pclk);
            acc = 0;
            while (penable === 1'b1 && acc < 40) begin
                chk("acc_sel", psel, 1'b1);
                chk("acc_bus", bus_obs, bus_exp(t));
                chk("acc_rsp", rsp_valid, 1'b0);
                acc++;
                last    = (acc == t.w + 1);
                pready  = last;
                pslverr = last ? t.err : 1'($urandom_range(0, 1));
                prdata  = last ? t.rdata : $urandom;
                if (last && t.chain && q.size() > 0) drive_req(q[0]);
                @(negedge pclk);
            end
            pready = 1'b0;
            tout = (t.w >= TO);
            chk("access_cycles", 64'(acc), 64'(tout ? TO : t.w + 1));
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, (tout || t.wr) ? '0 : t.rdata);
            chk("rsp_error", rsp_error, tout | t.err);
            chk("rsp_timeout", rsp_timeout, tout);
            pre = t.chain && !tout && q.size() > 0;
            chk("post_sel", {psel, penable}, pre ? 2'b10 : 2'b00);
            if (!pre) begin
                req_valid = 1'b0;
                @(negedge pclk);
                chk("rsp_pulse", rsp_valid, 1'b0);
                chk("rsp_hold", {rsp_error, rsp_timeout}, {tout | t.err, tout});
            end
        end
    endtask

    initial begin
        txn_t t;
        int   w;
        preset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_sel", {psel, penable}, 2'b00);
        chk("rst_bus", bus_obs, 64'd0);
        chk("rst_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, '0);
        preset = 1'b0;
        @(negedge pclk);

        // directed plan
        q.push_back(mk(10'd122, 3'b110, 1'b1, 32'd2772003, 4'b1111, 32'd0, 1'b1, 4, 1'b0));
        q.push_back(mk(10'd125, 3'b100, 1'b0, 32'h5555_aaaa, 4'b1011, 32'd2772003, 1'b0, 0, 1'b0));
        q.push_back(mk(10'd4, 3'b000, 1'b1, 32'h1234_5678, 4'b0011, 32'd0, 1'b0, 0, 1'b1));
        q.push_back(mk(10'd8, 3'b001, 1'b0, 32'd0, 4'b1111, 32'hcafe_f00d, 1'b0, 1, 1'b0));
        q.push_back(mk(10'd300, 3'b010, 1'b0, 32'd0, 4'b0000, 32'hdead_beef, 1'b0, 100, 1'b0));
        q.push_back(mk(10'd301, 3'b011, 1'b0, 32'd0, 4'b0000, 32'h0bad_f00d, 1'b0, 2, 1'b0));
        q.push_back(mk(10'd302, 3'b111, 1'b1, 32'h0f0f_0f0f, 4'b0101, 32'd0, 1'b0, TO - 1, 1'b0));
        run_q();

        // reset in the middle of wait states
        t = mk(10'd77, 3'b101, 1'b1, 32'h7777_7777, 4'b1111, 32'd0, 1'b0, 10, 1'b0);
        drive_req(t);
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (4) @(negedge pclk);
        chk("mid_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("mid_rst_sel", {psel, penable}, 2'b00);
        chk("mid_rst_bus", bus_obs, 64'd0);
        chk("mid_rst_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, '0);
        repeat (3) begin
            @(negedge pclk);
            chk("mid_rst_quiet", {rsp_valid, psel}, 2'b00);
        end
        q.push_back(mk(10'd78, 3'b010, 1'b0, 32'd0, 4'b1111, 32'h1357_9bdf, 1'b1, 1, 1'b0));
        run_q();

        // randomized traffic, biased toward the timeout boundary now and then
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                            : int'($urandom_range(0, 3));
            t = mk(AW'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), $urandom,
                   BW'($urandom), $urandom, 1'($urandom_range(0, 1)), w,
                   (w < TO) && ($urandom_range(0, 1) == 1));
            q.push_back(t);
        end
        run_q();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
